fl_scan_sched: RTL and testbench
================================

# fl_scan_sched

Round-robin scheduler that shares one serial find-length scan engine among `NREQ` requesters. It accepts a `W`-bit word from the winning requester and scans it MSB-first, one bit per clock, for the highest set bit. It returns that bit index, a found flag and the owner ID with a one-cycle done pulse. It sits between the requesting blocks and the length-finding datapath; the scan engine is internal to this block.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `W`, 16: scanned word width (power of 2, ≥ 2).
- `IW`, `$clog2(W)`: index width.
- `OW`, `$clog2(NREQ)`: owner ID width.

Ports:
- `clk_i`, in, 1: single clock, rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, `NREQ`: per-requester request, level.
- `data_i`, in, `NREQ*W`: requester n's word at bits `[n*W +: W]`; bit `W-1` is MSB.
- `flush_i`, in, 1: synchronous abort of the scan in progress.
- `gnt_o`, out, `NREQ`: one-hot acceptance pulse, one cycle.
- `busy_o`, out, 1: high while state ≠ IDLE.
- `done_o`, out, 1: result-valid pulse, one cycle.
- `owner_o`, out, `OW`: requester that the result belongs to.
- `idx_o`, out, `IW`: highest set bit index.
- `found_o`, out, 1: 1 if the word was non-zero.

## Operation
States are IDLE, SCAN and DONE.

IDLE:
- If any `req_i` bit is high at the clock edge, select the winner round-robin, searching upward from pointer `ptr` with wrap-around.
- On that edge:
  - latch `data_i[winner]` into the scan buffer;
  - set `cnt <= W-1`;
  - set `own <= winner` and `ptr <= winner+1 mod NREQ`;
  - register `gnt_o <=` onehot(winner);
  - go to SCAN.
- With no request, stay in IDLE.

SCAN, evaluated each cycle in this priority order:
1. `flush_i`: go to IDLE; `done_o` not asserted; result registers unchanged.
2. `buf[cnt]==1`: `idx <= cnt`, `found <= 1`, go to DONE.
3. `cnt==0`: `idx <= 0`, `found <= 0`, go to DONE.
4. Otherwise `cnt <= cnt-1`.

DONE:
- `done_o=1` for exactly this cycle.
- `owner_o`, `idx_o`, `found_o` are valid and hold their values until the next DONE.
- Unconditionally go to IDLE.
- `flush_i` is ignored in DONE and IDLE.

Requester rules:
- A requester keeps `req_i` high with `data_i` stable until it sees its `gnt_o` bit.
- After the grant, the requester's `req_i` and `data_i` no longer affect the scan.
- A request dropped before its grant is simply not served.
- Requests are accepted only in IDLE. Requests arriving in SCAN or DONE wait.

Arithmetic:
- `cnt` is `IW` bits and decrements only while `cnt > 0`, so it never wraps.
- `ptr` wraps from `NREQ-1` to 0.

## Timing
Reset (`rst_i` low), applied immediately and asynchronously:
- state IDLE;
- `ptr=0`, so requester 0 has the highest priority first;
- `gnt_o=0`, `busy_o=0`, `done_o=0`, `owner_o=0`, `idx_o=0`, `found_o=0`.

Reset mid-scan discards the job; no done pulse is produced.

Latency, with acceptance edge E0:
- `gnt_o` is high during cycle E0+1, which is also the first SCAN cycle.
- `busy_o` rises in that same cycle.
- For a highest set bit p, `done_o` is high during cycle E0+(W−p)+1. For W=16:
  - p=15 gives done at E0+2;
  - p=0 gives done at E0+17.
- For an all-zero word, `done_o` is at E0+W+1 with `found_o=0` and `idx_o=0`.
- `busy_o` falls the cycle after DONE.
- The earliest next acceptance edge is the edge ending the first IDLE cycle.
- Back-to-back job spacing is therefore latency+1 cycles.

Flush:
- `flush_i` sampled high in SCAN: `busy_o` is low in the next cycle and `done_o` is never asserted for that job.
- `ptr` has already advanced past the flushed owner.

## Test plan
- Reset, then `req_i=0001` with word0=16'h0100 → during reset all outputs are 0. Then:
  - `gnt_o=0001` for 1 cycle;
  - `done_o` at E0+9 with `idx_o=8`, `found_o=1`, `owner_o=0`;
  - `busy_o` low at E0+10.
- `req_i=0010` with word1=16'h8000 → `done_o` at E0+2 with `idx_o=15`. Then word1=0 → `done_o` at E0+17 with `found_o=0`, `idx_o=0`.
- All four requesters held high, each dropping its request at its own grant, with words 16'h0001, 16'h0030, 16'h0400, 16'hFFFF → grant order 0,1,2,3. Results in that order:
  - (owner 0, idx 0)
  - (owner 1, idx 5)
  - (owner 2, idx 10)
  - (owner 3, idx 15)
- Then req0 and req2 both high → grant order 0 then 2.
- Word 16'h0001 with `flush_i` pulsed at the 5th SCAN cycle → no `done_o`, `busy_o` low next cycle, previous `idx_o`/`owner_o` retained. A following req1 is then granted and completes normally.
- `rst_i` driven low mid-scan at E0+6 → all outputs 0 asynchronously, with no done pulse. After release, req3 and req0 together → req0 is granted first (`ptr` reset to 0).
- `req_i` asserted during DONE → no grant in DONE; grant pulse appears two cycles after DONE, i.e. accepted at the edge ending the IDLE cycle.

Source files
------------

// File: rtl/fl_scan_sched.sv
// fl_scan_sched: round-robin arbiter feeding a serial MSB-first
// highest-set-bit scan engine shared by NREQ requesters.
module fl_scan_sched #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IW   = $clog2(W),
    parameter int OW   = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] data_i,
    input  logic              flush_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [OW-1:0]     owner_o,
    output logic [IW-1:0]     idx_o,
    output logic              found_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   own_q, own_d;
    logic [W-1:0]    buf_q, buf_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]   res_own_q, res_own_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            found_q, found_d;

    logic            win_vld;
    logic [OW-1:0]   win;

    // Round-robin pick: first requester at or above ptr, wrapping.
    always_comb begin
        int j;
        j       = 0;
        win_vld = 1'b0;
        win     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_i[j]) begin
                win_vld = 1'b1;
                win     = OW'(j);
            end
        end
    end

    // Next-state logic for accept, scan and result capture.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        res_own_d = res_own_q;
        idx_d     = idx_q;
        found_d   = found_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    buf_d   = data_i[int'(win)*W +: W];
                    cnt_d   = {IW{1'b1}};
                    own_d   = win;
                    ptr_d   = (win == OW'(NREQ - 1)) ? '0 : win + 1'b1;
                    gnt_d   = NREQ'(1) << win;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (buf_q[cnt_q]) begin
                    idx_d     = cnt_q;
                    found_d   = 1'b1;
                    res_own_d = own_q;
                    state_d   = S_DONE;
                end else if (cnt_q == '0) begin
                    idx_d     = '0;
                    found_d   = 1'b0;
                    res_own_d = own_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            res_own_q <= '0;
            idx_q     <= '0;
            found_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            res_own_q <= res_own_d;
            idx_q     <= idx_d;
            found_q   <= found_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign owner_o = res_own_q;
    assign idx_o   = idx_q;
    assign found_o = found_q;

endmodule

// File: tb/tb_fl_scan_sched.sv
// tb_fl_scan_sched: directed checks of arbitration order, scan
// latency, flush and asynchronous reset behaviour.
module tb_fl_scan_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [63:0] data_i;
    logic        flush_i;
    logic [3:0]  gnt_o;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  owner_o;
    logic [3:0]  idx_o;
    logic        found_o;

    logic [15:0] w0, w1, w2, w3;
    int          n_chk = 0;
    int          n_err = 0;

    assign data_i = {w3, w2, w1, w0};

    always #5 clk_i = ~clk_i;

    fl_scan_sched #(.NREQ(4), .W(16)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .flush_i (flush_i),
        .gnt_o   (gnt_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .owner_o (owner_o),
        .idx_o   (idx_o),
        .found_o (found_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt"},   32'(gnt_o),   0);
        chk({tag, ".busy"},  32'(busy_o),  0);
        chk({tag, ".done"},  32'(done_o),  0);
        chk({tag, ".owner"}, 32'(owner_o), 0);
        chk({tag, ".idx"},   32'(idx_o),   0);
        chk({tag, ".found"}, 32'(found_o), 0);
    endtask

    // Called in an IDLE cycle with the request(s) already driven.
    task automatic job(input string tag, input logic [3:0] g,
                       input int lat, input int ix, input int fnd,
                       input int ow);
        int n;
        @(negedge clk_i);
        chk({tag, ".gnt"},  32'(gnt_o),  32'(g));
        chk({tag, ".busy"}, 32'(busy_o), 1);
        req_i = req_i & ~g;
        n = 1;
        while (!done_o && n < 40) begin
            @(negedge clk_i);
            n++;
            if (n == 2) chk({tag, ".gnt1"}, 32'(gnt_o), 0);
        end
        chk({tag, ".lat"},   32'(n),       32'(lat));
        chk({tag, ".idx"},   32'(idx_o),   32'(ix));
        chk({tag, ".found"}, 32'(found_o), 32'(fnd));
        chk({tag, ".owner"}, 32'(owner_o), 32'(ow));
        @(negedge clk_i);
        chk({tag, ".idle"},  32'(busy_o),  0);
        chk({tag, ".ndone"}, 32'(done_o),  0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk_zero("rst");
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        int seen;
        rst_i   = 1'b1;
        req_i   = '0;
        flush_i = 1'b0;
        {w0, w1, w2, w3} = '0;
        #2 rst_i = 1'b0;
        #1 chk_zero("por");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Single job, highest bit 8.
        w0 = 16'h0100;
        req_i = 4'b0001;
        job("j1", 4'b0001, 9, 8, 1, 0);

        // MSB set, then all-zero word.
        w1 = 16'h8000;
        req_i = 4'b0010;
        job("j2", 4'b0010, 2, 15, 1, 1);
        w1 = 16'h0000;
        req_i = 4'b0010;
        job("j3", 4'b0010, 17, 0, 0, 1);

        // All four competing from a fresh pointer.
        do_reset();
        w0 = 16'h0001; w1 = 16'h0030;
        w2 = 16'h0400; w3 = 16'hFFFF;
        req_i = 4'b1111;
        job("rr0", 4'b0001, 17, 0, 1, 0);
        job("rr1", 4'b0010, 12, 5, 1, 1);
        job("rr2", 4'b0100, 7, 10, 1, 2);
        job("rr3", 4'b1000, 2, 15, 1, 3);
        req_i = 4'b0101;
        job("p0", 4'b0001, 17, 0, 1, 0);
        job("p2", 4'b0100, 7, 10, 1, 2);

        // Flush during the 5th scan cycle.
        req_i = 4'b0001;
        seen = 0;
        @(negedge clk_i);
        chk("fl.gnt", 32'(gnt_o), 32'h1);
        req_i = '0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("fl.seen",  32'(seen),    0);
        chk("fl.busy",  32'(busy_o),  0);
        chk("fl.done",  32'(done_o),  0);
        chk("fl.idx",   32'(idx_o),   10);
        chk("fl.owner", 32'(owner_o), 2);
        chk("fl.found", 32'(found_o), 1);
        req_i = 4'b0010;
        job("fl1", 4'b0010, 12, 5, 1, 1);

        // Reset in the middle of a scan.
        w2 = 16'h0001;
        req_i = 4'b0100;
        seen = 0;
        @(negedge clk_i);
        chk("mr.gnt", 32'(gnt_o), 32'h4);
        req_i = '0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        rst_i = 1'b0;
        #1;
        chk("mr.seen", 32'(seen), 0);
        chk_zero("mr");
        @(negedge clk_i);
        chk("mr.hold", 32'(busy_o), 0);
        rst_i = 1'b1;
        req_i = 4'b1001;
        job("mr0", 4'b0001, 17, 0, 1, 0);
        job("mr3", 4'b1000, 2, 15, 1, 3);

        // Request raised during DONE waits for IDLE.
        w1 = 16'h8000;
        req_i = 4'b0010;
        @(negedge clk_i);
        chk("rd.gnt", 32'(gnt_o), 32'h2);
        req_i = '0;
        @(negedge clk_i);
        chk("rd.done", 32'(done_o), 1);
        w2 = 16'h0030;
        req_i = 4'b0100;
        @(negedge clk_i);
        chk("rd.nogn", 32'(gnt_o),  0);
        chk("rd.idle", 32'(busy_o), 0);
        job("rd2", 4'b0100, 12, 5, 1, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
